ltl_symbol_streamer: RTL

Producer side of the LTL monitor automata. It takes one 8-bit atomic-proposition vector per qualified core event, buffers it in a small FIFO, and replays it as one symbol per cycle on the automaton's symbols/run/reset interface. It frames each trace so that the automaton's start-of-data cycle carries exactly the first buffered symbol. It sits between the core trace tap and one monitor cluster's automata instance.

---
 rtl/ltl_symbol_streamer_if.sv | 29 ++
 rtl/ltl_symbol_streamer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ltl_symbol_streamer_if.sv
// Signal bundle between the trace tap/control side (master) and the
// symbol streamer (slave) that feeds one automaton instance.
interface ltl_symbol_streamer_if #(
    parameter int CNT_W = 16
);
    logic             prop_valid;
    logic [7:0]       prop_data;
    logic             trace_start;
    logic             trace_end;
    logic             enable;
    logic             aut_reset;
    logic             aut_run;
    logic [7:0]       aut_symbols;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W-1:0] sym_count;

    modport master (
        output prop_valid, prop_data, trace_start, trace_end, enable,
        input  aut_reset, aut_run, aut_symbols, busy, done, overflow, drop_count, sym_count
    );

    modport slave (
        input  prop_valid, prop_data, trace_start, trace_end, enable,
        output aut_reset, aut_run, aut_symbols, busy, done, overflow, drop_count, sym_count
    );
endinterface

// File: rtl/ltl_symbol_streamer.sv
// Buffers per-event proposition vectors and replays them one symbol per cycle,
// framing each trace so the first cycle with aut_reset low carries the first symbol.
module ltl_symbol_streamer #(
    parameter int DEPTH   = 8,
    parameter int MIN_RST = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    ltl_symbol_streamer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ARM_W = (MIN_RST > 1) ? $clog2(MIN_RST) : 1;
    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);
    localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(MIN_RST - 1);

    typedef enum logic [1:0] {IDLE, ARM, STREAM, DRAIN} state_t;

    state_t state_reg, state_next;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]   wr_ptr_reg, wr_ptr_next;
    logic [ARM_W-1:0] arm_cnt_reg, arm_cnt_next;
    logic             end_pending_reg, end_pending_next;
    logic             aut_reset_reg, aut_reset_next;
    logic             aut_run_reg, aut_run_next;
    logic [7:0]       aut_symbols_reg, aut_symbols_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             overflow_reg, overflow_next;
    logic [CNT_W-1:0] drop_count_reg, drop_count_next;
    logic [CNT_W-1:0] sym_count_reg, sym_count_next;

    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;
    logic             pop;
    logic             accept;
    logic             empty;
    logic             full;
    logic [7:0]       head;

    // Extra MSB on the pointers separates full from empty when the low bits match.
    assign empty = (rd_ptr_reg == wr_ptr_reg);
    assign full  = (rd_ptr_reg[PTR_W] != wr_ptr_reg[PTR_W]) &&
                   (rd_ptr_reg[PTR_W-1:0] == wr_ptr_reg[PTR_W-1:0]);
    assign head  = mem[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.prop_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        rd_ptr_next      = rd_ptr_reg;
        wr_ptr_next      = wr_ptr_reg;
        arm_cnt_next     = arm_cnt_reg;
        end_pending_next = end_pending_reg;
        aut_reset_next   = aut_reset_reg;
        aut_run_next     = 1'b0;
        aut_symbols_next = aut_symbols_reg;
        done_next        = 1'b0;
        overflow_next    = overflow_reg;
        drop_count_next  = drop_count_reg;
        sym_count_next   = sym_count_reg;
        wr_en            = 1'b0;
        wr_addr          = wr_ptr_reg[PTR_W-1:0];
        pop              = 1'b0;
        accept           = 1'b0;

        if (bus.trace_start) begin
            // Start or abort: flush, then the same-cycle prop becomes entry 0.
            state_next       = ARM;
            rd_ptr_next      = '0;
            wr_ptr_next      = bus.prop_valid ? PTR_ONE : '0;
            wr_en            = bus.prop_valid;
            wr_addr          = '0;
            arm_cnt_next     = ARM_LOAD;
            end_pending_next = 1'b0;
            aut_reset_next   = 1'b1;
            overflow_next    = 1'b0;
            drop_count_next  = '0;
            sym_count_next   = '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    aut_reset_next = 1'b1;
                end
                ARM: begin
                    if (arm_cnt_reg != '0) begin
                        arm_cnt_next = arm_cnt_reg - ARM_ONE;
                    end
                    if (bus.trace_end && empty) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        // An end seen before the first symbol is honoured once streaming starts.
                        if (bus.trace_end) begin
                            end_pending_next = 1'b1;
                        end
                        if (arm_cnt_reg == '0 && !empty && bus.enable) begin
                            pop            = 1'b1;
                            aut_reset_next = 1'b0;
                            state_next     = (end_pending_reg || bus.trace_end) ? DRAIN : STREAM;
                        end
                    end
                end
                STREAM: begin
                    pop = !empty && bus.enable;
                    if (bus.trace_end) begin
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state_next     = IDLE;
                        aut_reset_next = 1'b1;
                        done_next      = 1'b1;
                    end else begin
                        pop = bus.enable;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            accept = bus.prop_valid && (state_reg == ARM || state_reg == STREAM);
            if (accept) begin
                if (!full || pop) begin
                    wr_en       = 1'b1;
                    wr_ptr_next = wr_ptr_reg + PTR_ONE;
                end else begin
                    overflow_next = 1'b1;
                    if (drop_count_reg != '1) begin
                        drop_count_next = drop_count_reg + CNT_ONE;
                    end
                end
            end

            if (pop) begin
                rd_ptr_next      = rd_ptr_reg + PTR_ONE;
                aut_run_next     = 1'b1;
                aut_symbols_next = head;
                sym_count_next   = sym_count_reg + CNT_ONE;
            end
        end

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            arm_cnt_reg     <= '0;
            end_pending_reg <= 1'b0;
            aut_reset_reg   <= 1'b1;
            aut_run_reg     <= 1'b0;
            aut_symbols_reg <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            overflow_reg    <= 1'b0;
            drop_count_reg  <= '0;
            sym_count_reg   <= '0;
        end else begin
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
            arm_cnt_reg     <= arm_cnt_next;
            end_pending_reg <= end_pending_next;
            aut_reset_reg   <= aut_reset_next;
            aut_run_reg     <= aut_run_next;
            aut_symbols_reg <= aut_symbols_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            overflow_reg    <= overflow_next;
            drop_count_reg  <= drop_count_next;
            sym_count_reg   <= sym_count_next;
        end
    end

    assign bus.aut_reset   = aut_reset_reg;
    assign bus.aut_run     = aut_run_reg;
    assign bus.aut_symbols = aut_symbols_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.overflow    = overflow_reg;
    assign bus.drop_count  = drop_count_reg;
    assign bus.sym_count   = sym_count_reg;

endmodule
